// File: rtl/ibex_efpga_ctrl.sv
// EX-stage initiator for eFPGA custom instructions: latches operands, issues a
// one-cycle enable, waits for the responder (with timeout) and writes back once.
module ibex_efpga_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [3:0]  DEFAULT_DELAY  = 4'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    input  logic        cfg_delay_we_i,
    input  logic [3:0]  cfg_delay_i,
    output logic        ex_ready_o,
    output logic        efpga_en_o,
    output logic [1:0]  efpga_operator_o,
    output logic [31:0] efpga_operand_a_o,
    output logic [31:0] efpga_operand_b_o,
    output logic [3:0]  efpga_delay_o,
    input  logic        efpga_ready_i,
    input  logic [31:0] efpga_result_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        timeout_err_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, WB} state_e;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [9:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q, wb_data_q;
    logic [4:0]  rd_q;
    logic [3:0]  delay_q, pend_val_q;
    logic        pend_q;
    logic        timeout_hit, busy, counting_q, counting_d;

    assign timeout_hit = (cnt_q >= TO_LAST);
    assign busy        = (state_q == ISSUE) || (state_q == WAIT) || (state_q == DRAIN);
    assign counting_q  = (state_q == WAIT) || (state_q == DRAIN);
    assign counting_d  = (state_d == WAIT) || (state_d == DRAIN);

    always_comb begin
        state_d       = state_q;
        ex_ready_o    = 1'b0;
        timeout_err_o = 1'b0;
        case (state_q)
            IDLE: begin
                ex_ready_o = !instr_valid_i || flush_i;
                if (instr_valid_i && !flush_i) state_d = ISSUE;
            end
            ISSUE: state_d = flush_i ? DRAIN : WAIT;
            WAIT: begin
                // ready beats flush; flush beats timeout
                if (efpga_ready_i) begin
                    state_d = WB;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end else if (timeout_hit) begin
                    timeout_err_o = 1'b1;
                    state_d       = WB;
                end
            end
            DRAIN: begin
                if (efpga_ready_i) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    timeout_err_o = 1'b1;
                    state_d       = IDLE;
                end
            end
            WB: begin
                ex_ready_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            delay_q    <= DEFAULT_DELAY;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (counting_q && counting_d) ? cnt_q + 10'd1 : '0;

            if (state_q == IDLE && state_d == ISSUE) begin
                op_q <= op_i;
                a_q  <= operand_a_i;
                b_q  <= operand_b_i;
                rd_q <= rd_addr_i;
            end

            if (state_q == WAIT && state_d == WB)
                wb_data_q <= efpga_ready_i ? efpga_result_i : '0;

            // Delay must not change under an in-flight op; writes queue until IDLE.
            if (busy) begin
                if (state_d == IDLE) begin
                    if (cfg_delay_we_i)  delay_q <= cfg_delay_i;
                    else if (pend_q)     delay_q <= pend_val_q;
                    pend_q <= 1'b0;
                end else if (cfg_delay_we_i) begin
                    pend_q     <= 1'b1;
                    pend_val_q <= cfg_delay_i;
                end
            end else begin
                if (cfg_delay_we_i)  delay_q <= cfg_delay_i;
                else if (pend_q)     delay_q <= pend_val_q;
                pend_q <= 1'b0;
            end
        end
    end

    assign efpga_en_o        = (state_q == ISSUE);
    assign wb_valid_o        = (state_q == WB) && !flush_i;
    assign efpga_operator_o  = op_q;
    assign efpga_operand_a_o = a_q;
    assign efpga_operand_b_o = b_q;
    assign efpga_delay_o     = delay_q;
    assign wb_addr_o         = rd_q;
    assign wb_data_o         = wb_data_q;

endmodule

// File: tb/tb_ibex_efpga_ctrl.sv
// Self-checking bench for ibex_efpga_ctrl: directed scenarios plus randomized
// operations checked against a cycle-count/transaction model.
module tb_ibex_efpga_ctrl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid_i;
    logic [1:0]  op_i;
    logic [31:0] operand_a_i, operand_b_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i, cfg_delay_we_i;
    logic [3:0]  cfg_delay_i;
    logic        ex_ready_o, efpga_en_o;
    logic [1:0]  efpga_operator_o;
    logic [31:0] efpga_operand_a_o, efpga_operand_b_o;
    logic [3:0]  efpga_delay_o;
    logic        efpga_ready_i;
    logic [31:0] efpga_result_i;
    logic        wb_valid_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic        timeout_err_o;

    int checks = 0;
    int failures = 0;
    logic [3:0] delay_m;

    always #5 clk = ~clk;

    ibex_efpga_ctrl #(.TIMEOUT_CYCLES(T), .DEFAULT_DELAY(4'd3)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_i(instr_valid_i), .op_i(op_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .cfg_delay_we_i(cfg_delay_we_i), .cfg_delay_i(cfg_delay_i),
        .ex_ready_o(ex_ready_o), .efpga_en_o(efpga_en_o),
        .efpga_operator_o(efpga_operator_o),
        .efpga_operand_a_o(efpga_operand_a_o), .efpga_operand_b_o(efpga_operand_b_o),
        .efpga_delay_o(efpga_delay_o),
        .efpga_ready_i(efpga_ready_i), .efpga_result_i(efpga_result_i),
        .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .timeout_err_o(timeout_err_o)
    );

    function automatic logic [31:0] resp_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a;
            2'd1:    return a + b;
            2'd2:    return a ^ b;
            default: return a - b;
        endcase
    endfunction

    task automatic idle_inputs();
        instr_valid_i  = 1'b0;
        flush_i        = 1'b0;
        cfg_delay_we_i = 1'b0;
        cfg_delay_i    = 4'($urandom);
        efpga_ready_i  = 1'b0;
        efpga_result_i = $urandom;
        op_i           = 2'($urandom);
        operand_a_i    = $urandom;
        operand_b_i    = $urandom;
        rd_addr_i      = 5'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if ({efpga_en_o, wb_valid_o, timeout_err_o, ex_ready_o} !== 4'b0001) begin
            failures++;
            $display("FAIL %s pulses en/wb/to/rdy got=%b exp=0001", tag,
                     {efpga_en_o, wb_valid_o, timeout_err_o, ex_ready_o});
        end
        checks++;
        if ({efpga_operator_o, efpga_operand_a_o, efpga_operand_b_o, wb_addr_o, wb_data_o} !== '0) begin
            failures++;
            $display("FAIL %s regs op=%h a=%h b=%h rd=%h wbd=%h exp all 0", tag, efpga_operator_o,
                     efpga_operand_a_o, efpga_operand_b_o, wb_addr_o, wb_data_o);
        end
        checks++;
        if (efpga_delay_o !== 4'd3) begin
            failures++;
            $display("FAIL %s delay got=%0d exp=3", tag, efpga_delay_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        delay_m = 4'd3;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
    endtask

    // One instruction accepted at n=0. rc: responder ready cycle (<2 = none),
    // f: flush cycle (0 = none), fwb: flush during writeback, wc/wv: delay write,
    // hold: keep a second instruction presented to test back-to-back acceptance.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int rc, input int f_in, input bit fwb_in,
                          input int wc, input logic [3:0] wv, input bit hold, input string tag);
        int c, f, last;
        bit is_to, flushed, fwb, hold_e;
        logic [31:0] expd, a2, b2;
        logic [1:0] op2;
        logic [4:0] rd2;
        logic [3:0] old_d, new_d, e_dly;
        logic e_en, e_rdy, e_to, e_wb;

        is_to   = !(rc >= 2 && rc <= T + 1);
        c       = is_to ? T + 1 : rc;
        f       = f_in;
        if (f > c || (is_to && f == c)) f = 0;
        flushed = (f >= 1 && f < c);
        fwb     = fwb_in && !flushed;
        hold_e  = hold && !flushed;
        expd    = is_to ? 32'd0 : resp_fn(op, a, b);
        old_d   = delay_m;
        new_d   = (wc >= 1 && wc <= c) ? wv : old_d;
        op2 = 2'($urandom); a2 = $urandom; b2 = $urandom; rd2 = rd + 5'd1;
        last = hold_e ? c + 3 : c + 2;

        for (int n = 0; n <= last; n++) begin
            instr_valid_i  = (n == 0) || (hold_e && n >= 1);
            op_i           = (n == 0) ? op : op2;
            operand_a_i    = (n == 0) ? a : a2;
            operand_b_i    = (n == 0) ? b : b2;
            rd_addr_i      = (n == 0) ? rd : rd2;
            flush_i        = (f >= 1 && n == f) || (fwb && n == c + 1);
            cfg_delay_we_i = (wc >= 1 && wc <= c && n == wc);
            cfg_delay_i    = cfg_delay_we_i ? wv : 4'($urandom);
            efpga_ready_i  = (rc >= 2 && n == rc);
            efpga_result_i = efpga_ready_i ?
                             resp_fn(efpga_operator_o, efpga_operand_a_o, efpga_operand_b_o) : $urandom;
            @(negedge clk);

            e_en  = (n == 1) || (hold_e && n == c + 3);
            e_rdy = (n >= c + 1) && !(hold_e && n >= c + 2);
            e_to  = is_to && (n == c);
            e_wb  = !flushed && !fwb && (n == c + 1);
            e_dly = (n <= c || (n == c + 1 && !flushed)) ? old_d : new_d;

            checks++;
            if (efpga_en_o !== e_en) begin
                failures++; $display("FAIL %s n=%0d en got=%b exp=%b", tag, n, efpga_en_o, e_en);
            end
            checks++;
            if (ex_ready_o !== e_rdy) begin
                failures++; $display("FAIL %s n=%0d ex_ready got=%b exp=%b", tag, n, ex_ready_o, e_rdy);
            end
            checks++;
            if (timeout_err_o !== e_to) begin
                failures++; $display("FAIL %s n=%0d timeout got=%b exp=%b", tag, n, timeout_err_o, e_to);
            end
            checks++;
            if (wb_valid_o !== e_wb) begin
                failures++; $display("FAIL %s n=%0d wb_valid got=%b exp=%b", tag, n, wb_valid_o, e_wb);
            end
            checks++;
            if (efpga_delay_o !== e_dly) begin
                failures++; $display("FAIL %s n=%0d delay got=%0d exp=%0d", tag, n, efpga_delay_o, e_dly);
            end
            if (n >= 1 && n <= c + 2) begin
                checks++;
                if ({efpga_operator_o, efpga_operand_a_o, efpga_operand_b_o} !== {op, a, b}) begin
                    failures++;
                    $display("FAIL %s n=%0d operands got=%h/%h/%h exp=%h/%h/%h", tag, n, efpga_operator_o,
                             efpga_operand_a_o, efpga_operand_b_o, op, a, b);
                end
            end
            if (n == c + 3) begin
                checks++;
                if ({efpga_operator_o, efpga_operand_a_o, efpga_operand_b_o, wb_addr_o} !== {op2, a2, b2, rd2}) begin
                    failures++;
                    $display("FAIL %s n=%0d second operands got=%h/%h/%h/%h exp=%h/%h/%h/%h", tag, n,
                             efpga_operator_o, efpga_operand_a_o, efpga_operand_b_o, wb_addr_o, op2, a2, b2, rd2);
                end
            end
            if (n == c + 1 && !flushed) begin
                checks++;
                if ({wb_data_o, wb_addr_o} !== {expd, rd}) begin
                    failures++;
                    $display("FAIL %s n=%0d wb data/addr got=%h/%0d exp=%h/%0d", tag, n, wb_data_o, wb_addr_o, expd, rd);
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        delay_m = new_d;
        if (hold_e) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            delay_m = 4'd3;
        end
    endtask

    task automatic test_normal();
        run_op(2'd0, 32'h1234_5678, $urandom, 5'd5, 7, 0, 1'b0, 0, 4'd0, 1'b0, "normal");
    endtask

    task automatic test_timeout();
        run_op(2'd1, $urandom, $urandom, 5'd9, 0, 0, 1'b0, 0, 4'd0, 1'b0, "timeout");
        run_op(2'd2, $urandom, $urandom, 5'd4, 1, 5, 1'b0, 0, 4'd0, 1'b0, "timeout_drain");
    endtask

    task automatic test_flush();
        run_op(2'd2, $urandom, $urandom, 5'd7, 7, 3, 1'b0, 0, 4'd0, 1'b0, "flush_wait");
        run_op(2'd3, $urandom, $urandom, 5'd8, 5, 1, 1'b0, 0, 4'd0, 1'b0, "flush_issue");
        run_op(2'd1, $urandom, $urandom, 5'd3, 6, 6, 1'b0, 0, 4'd0, 1'b0, "ready_flush");
        run_op(2'd1, $urandom, $urandom, 5'd3, 6, 6, 1'b1, 0, 4'd0, 1'b0, "ready_flush_wb");
    endtask

    task automatic test_delay_write();
        run_op(2'd0, $urandom, $urandom, 5'd2, 7, 0, 1'b0, 4, 4'd9, 1'b0, "delay_wait");
        run_op(2'd0, $urandom, $urandom, 5'd2, 7, 3, 1'b0, 5, 4'd12, 1'b0, "delay_drain");
    endtask

    task automatic test_back_to_back();
        run_op(2'd3, $urandom, $urandom, 5'd11, 4, 0, 1'b0, 0, 4'd0, 1'b1, "back_to_back");
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] a;
        a = $urandom;
        for (int n = 0; n <= 9; n++) begin
            idle_inputs();
            rst_n          = !(n == 4);
            instr_valid_i  = (n == 0);
            op_i           = 2'd0;
            operand_a_i    = a | 32'h1;
            rd_addr_i      = 5'd17;
            cfg_delay_we_i = (n == 3);
            cfg_delay_i    = 4'd9;
            efpga_ready_i  = (n == 6 || n == 8);
            @(negedge clk);
            if (n == 5) check_reset_vals("reset_mid_wait");
            if (n >= 6) begin
                checks++;
                if ({efpga_en_o, wb_valid_o, timeout_err_o, ex_ready_o, wb_data_o} !== {4'b0001, 32'd0}) begin
                    failures++;
                    $display("FAIL late_ready n=%0d en/wb/to/rdy got=%b wbd=%h exp=0001 wbd=0", n,
                             {efpga_en_o, wb_valid_o, timeout_err_o, ex_ready_o}, wb_data_o);
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        delay_m = 4'd3;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), $urandom, $urandom, 5'($urandom),
                   $urandom_range(2, T + 3),
                   ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, T + 1),
                   ($urandom_range(0, 3) == 0),
                   $urandom_range(0, T + 1), 4'($urandom),
                   ($urandom_range(0, 3) == 0), "random");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        delay_m = 4'd3;
        test_reset();
        test_normal();
        test_timeout();
        test_flush();
        test_delay_write();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibex_efpga_ctrl.md
Name: ibex_efpga_ctrl

Overview:
- Initiator side of the eFPGA custom-instruction interface; sits in the EX stage between the ID stage and the eFPGA responder.
- Accepts one custom instruction from ID, latches its operands, and drives a single-cycle enable to the eFPGA.
- Waits for the responder's one-cycle ready pulse, with a timeout, then presents a one-cycle writeback.
- Stalls ID through ex_ready_o while an operation is outstanding; supports pipeline flush with safe draining of the in-flight eFPGA operation.

Parameters:
- TIMEOUT_CYCLES, 64: WAIT/DRAIN cycles allowed before the operation is abandoned with an error; legal range 2..1023.
- DEFAULT_DELAY, 4'd3: value driven on efpga_delay_o when cfg_delay_we_i has never been written since reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- instr_valid_i  in  1  ID presents a custom eFPGA instruction
- op_i  in  2  operator code
- operand_a_i  in  32  operand A
- operand_b_i  in  32  operand B
- rd_addr_i  in  5  destination register
- flush_i  in  1  kill the current instruction; result must not be written back
- cfg_delay_we_i  in  1  load cfg_delay_i into the delay register
- cfg_delay_i  in  4  new delay value
- ex_ready_o  out  1  high = EX can accept or has completed; low = stall ID
- efpga_en_o  out  1  request pulse to the eFPGA
- efpga_operator_o  out  2  latched operator
- efpga_operand_a_o  out  32  latched operand A
- efpga_operand_b_o  out  32  latched operand B
- efpga_delay_o  out  4  delay register contents
- efpga_ready_i  in  1  one-cycle completion pulse from the eFPGA
- efpga_result_i  in  32  result; valid in the cycle efpga_ready_i is high
- wb_valid_o  out  1  one-cycle writeback strobe
- wb_addr_o  out  5  writeback register
- wb_data_o  out  32  writeback data
- timeout_err_o  out  1  one-cycle pulse when an operation is abandoned

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; timeout counter to 0.
  - Operand, operator, rd and wb_data registers go to 0; delay register goes to DEFAULT_DELAY.
  - All pulse outputs go to 0.
  - Reset takes effect mid-operation; a late efpga_ready_i after reset lands in IDLE and is ignored.
- States: IDLE, ISSUE, WAIT, DRAIN, WB.
- IDLE:
  - If instr_valid_i && !flush_i: latch op, operands and rd; go to ISSUE.
  - ex_ready_o = !instr_valid_i || flush_i, computed combinationally in IDLE.
- ISSUE:
  - efpga_en_o = 1 for exactly this one cycle.
  - Next state is WAIT; on flush_i, next state is DRAIN instead, because the enable has already been issued.
- WAIT:
  - Timeout counter increments each cycle.
  - On efpga_ready_i: capture efpga_result_i into wb_data; go to WB.
  - Else on flush_i: go to DRAIN with the counter kept.
  - Else when the counter reaches TIMEOUT_CYCLES-1: pulse timeout_err_o, set wb_data to 0, go to WB.
  - efpga_ready_i wins over a simultaneous flush_i.
- DRAIN:
  - Counter keeps incrementing.
  - On efpga_ready_i, or on timeout (timeout_err_o pulses): go to IDLE; no writeback.
- WB:
  - wb_valid_o = 1 and ex_ready_o = 1 for one cycle; clear counter; go to IDLE.
  - flush_i in WB suppresses wb_valid_o.
  - A new instruction is not accepted in WB; earliest acceptance is the following IDLE cycle.
- ex_ready_o is 0 in ISSUE, WAIT and DRAIN.
- wb_addr_o always shows the latched rd.
- efpga_operator_o and efpga_operand_*_o hold their latched values from ISSUE until the next acceptance.
- efpga_ready_i in IDLE, ISSUE or WB is ignored, with no state change.
- Delay register:
  - Written on cfg_delay_we_i in any state.
  - efpga_delay_o must stay stable from ISSUE until the operation completes; a write during ISSUE, WAIT or DRAIN is held pending and applied on return to IDLE.
- Latency: instruction accepted at cycle 0 → en_o high at cycle 1. For a responder with delay d, ready arrives at cycle d+4, wb_valid_o is high at cycle d+5, and the next instruction is accepted at cycle d+6 at the earliest.

Test Plan:
- Normal op: delay 3, op=0, A=0x1234_5678, rd=5, responder returns A → en_o one pulse at cycle 1; wb_valid_o at cycle 8 with wb_data_o=0x1234_5678, wb_addr_o=5; ex_ready_o low from cycle 0 through cycle 7.
- Timeout: TIMEOUT_CYCLES=8, responder never answers → timeout_err_o pulses on the 8th WAIT cycle; wb_valid_o next cycle with wb_data_o=0.
- Flush in WAIT: flush_i at cycle 3, responder ready at cycle 7 → no wb_valid_o, no timeout_err_o; IDLE at cycle 8; next instruction accepted.
- Ready and flush together in WAIT → WB taken; wb_valid_o=1 with the result unless flush_i is also high in WB.
- Delay write: cfg_delay_i=9 written during WAIT of an op started with delay 3 → efpga_delay_o stays 3 until IDLE, then reads 9.
- Reset mid-WAIT, then a late efpga_ready_i → outputs at reset values; no wb_valid_o; state stays IDLE.
